axis_pfifo: RTL and testbench



---
 rtl/axis_pfifo_pkg.sv | 18 +
 rtl/axis_pfifo_ram.sv | 25 ++
 rtl/axis_pfifo.sv | 162 ++++++++++++++++
 tb/tb_axis_pfifo.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pfifo_pkg.sv
// Shared types and helpers for the axis_pfifo stream FIFO.
// Holds the packet-tracking state encoding and the wrap-aware pointer distance.
package axis_pfifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    DROP = 2'd2
  } pf_state_e;

  // Distance a-b on pointers that are abits+1 wide and wrap modulo 2**(abits+1).
  function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          abits);
    return (a - b) & ((32'd2 << abits) - 32'd1);
  endfunction

endpackage

// File: rtl/axis_pfifo_ram.sv
// Simple dual-port storage for axis_pfifo: synchronous write, asynchronous read.
// Kept separate so the memory can be swapped for a vendor primitive.
module axis_pfifo_ram #(
  parameter int WIDTH = 9,
  parameter int ABITS = 4
) (
  input  logic             aclk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ABITS)-1];

  always_ff @(posedge aclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pfifo.sv
// Single-clock AXI4-Stream FIFO with optional store-and-forward (PACKET=1).
// Define AXIS_PFIFO_DROP_EN to add drop_o and discard packets too long to ever fit.
module axis_pfifo
  import axis_pfifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ABITS  = 4,
  parameter int PACKET = 0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic [ABITS:0]   level_o
`ifdef AXIS_PFIFO_DROP_EN
  ,
  output logic             drop_o
`endif
);

  localparam int          PW    = ABITS + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ABITS;

  pf_state_e        state_reg, state_next;
  logic [ABITS:0]   wr_ptr_reg, wr_ptr_next;
  logic [ABITS:0]   wr_cmt_reg, wr_cmt_next;
  logic [ABITS:0]   rd_ptr_reg, rd_ptr_next;
  logic             s_tready_reg, s_tready_next;
  logic             m_tvalid_reg;
  logic             m_tlast_reg;
  logic [WIDTH-1:0] m_tdata_reg;
  logic             accept;
  logic             load;
  logic             ram_we;
  logic [WIDTH:0]   ram_rdata;
`ifdef AXIS_PFIFO_DROP_EN
  logic             drop_reg, drop_next;
`endif

  assign accept = s_tvalid_i & s_tready_reg;
  // Only committed entries may move into the output register.
  assign load   = (rd_ptr_reg != wr_cmt_reg) & (~m_tvalid_reg | m_tready_i);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    wr_cmt_next = wr_cmt_reg;
    state_next  = state_reg;
    ram_we      = 1'b0;
`ifdef AXIS_PFIFO_DROP_EN
    drop_next   = 1'b0;
`endif
    rd_ptr_next = load ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    if (PACKET == 0) begin
      if (accept) begin
        ram_we      = 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
        wr_cmt_next = wr_ptr_reg + 1'b1;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (s_tlast_i) wr_cmt_next = wr_ptr_reg + 1'b1;
            else           state_next  = OPEN;
          end
        end
        OPEN: begin
`ifdef AXIS_PFIFO_DROP_EN
          // An open packet already filling the whole RAM can never commit.
          if (s_tvalid_i && ptr_dist(32'(wr_ptr_reg), 32'(wr_cmt_reg), ABITS) == DEPTH) begin
            wr_ptr_next = wr_cmt_reg;
            state_next  = DROP;
          end else
`endif
          if (accept) begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (s_tlast_i) begin
              wr_cmt_next = wr_ptr_reg + 1'b1;
              state_next  = IDLE;
            end
          end
        end
`ifdef AXIS_PFIFO_DROP_EN
        DROP: begin
          if (accept && s_tlast_i) begin
            state_next = IDLE;
            drop_next  = 1'b1;
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end

    s_tready_next = (state_next == DROP) ||
                    (ptr_dist(32'(wr_ptr_next), 32'(rd_ptr_next), ABITS) < DEPTH);
  end

  axis_pfifo_ram #(
    .WIDTH(WIDTH + 1),
    .ABITS(ABITS)
  ) u_ram (
    .aclk  (aclk),
    .we    (ram_we),
    .waddr (wr_ptr_reg[ABITS-1:0]),
    .wdata ({s_tlast_i, s_tdata_i}),
    .raddr (rd_ptr_reg[ABITS-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      wr_cmt_reg   <= '0;
      rd_ptr_reg   <= '0;
      s_tready_reg <= 1'b0;
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
      m_tdata_reg  <= '0;
`ifdef AXIS_PFIFO_DROP_EN
      drop_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      wr_cmt_reg   <= wr_cmt_next;
      rd_ptr_reg   <= rd_ptr_next;
      s_tready_reg <= s_tready_next;
`ifdef AXIS_PFIFO_DROP_EN
      drop_reg     <= drop_next;
`endif
      if (load) begin
        m_tvalid_reg <= 1'b1;
        m_tlast_reg  <= ram_rdata[WIDTH];
        m_tdata_reg  <= ram_rdata[WIDTH-1:0];
      end else if (m_tready_i) begin
        m_tvalid_reg <= 1'b0;
      end
    end
  end

  assign s_tready_o = s_tready_reg;
  assign m_tvalid_o = m_tvalid_reg;
  assign m_tlast_o  = m_tlast_reg;
  assign m_tdata_o  = m_tdata_reg;
  assign level_o    = PW'(ptr_dist(32'(wr_ptr_reg), 32'(rd_ptr_reg), ABITS));
`ifdef AXIS_PFIFO_DROP_EN
  assign drop_o     = drop_reg;
`endif

endmodule

// File: tb/tb_axis_pfifo.sv
// Directed bench for axis_pfifo: three instances (cut-through, store-and-forward,
// small wrap/drop instance) checked against a bench-side beat scoreboard.
module tb_axis_pfifo;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         e;
  } beat_t;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [2:0]      s_tvalid = '0;
  logic [2:0]      s_tready;
  logic [2:0]      s_tlast = '0;
  logic [2:0][7:0] s_tdata = '0;
  logic [2:0]      m_tvalid;
  logic [2:0]      m_tready = '0;
  logic [2:0]      m_tlast;
  logic [2:0][7:0] m_tdata;
  logic [3:0]      level0;
  logic [4:0]      level1;
  logic [2:0]      level2;
`ifdef AXIS_PFIFO_DROP_EN
  logic            drop0, drop1, drop2;
  int              drop_cnt = 0;
`endif

  beat_t sb0[$];
  beat_t sb1[$];
  beat_t sb2[$];
  logic [2:0] skip = '0;
  logic [2:0] acc_flag = '0;
  int acc_cnt[3] = '{0, 0, 0};
  int out_cnt[3] = '{0, 0, 0};
  int cyc = 0;
  bit lat_chk = 1'b0;
  int n_err = 0;
  int n_checks = 0;

  always #5 aclk = ~aclk;

  axis_pfifo #(.WIDTH(8), .ABITS(3), .PACKET(0)) u0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid_i(s_tvalid[0]), .s_tready_o(s_tready[0]), .s_tlast_i(s_tlast[0]), .s_tdata_i(s_tdata[0]),
    .m_tvalid_o(m_tvalid[0]), .m_tready_i(m_tready[0]), .m_tlast_o(m_tlast[0]), .m_tdata_o(m_tdata[0]),
    .level_o(level0)
`ifdef AXIS_PFIFO_DROP_EN
    , .drop_o(drop0)
`endif
  );

  axis_pfifo #(.WIDTH(8), .ABITS(4), .PACKET(1)) u1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid_i(s_tvalid[1]), .s_tready_o(s_tready[1]), .s_tlast_i(s_tlast[1]), .s_tdata_i(s_tdata[1]),
    .m_tvalid_o(m_tvalid[1]), .m_tready_i(m_tready[1]), .m_tlast_o(m_tlast[1]), .m_tdata_o(m_tdata[1]),
    .level_o(level1)
`ifdef AXIS_PFIFO_DROP_EN
    , .drop_o(drop1)
`endif
  );

  axis_pfifo #(.WIDTH(8), .ABITS(2), .PACKET(1)) u2 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid_i(s_tvalid[2]), .s_tready_o(s_tready[2]), .s_tlast_i(s_tlast[2]), .s_tdata_i(s_tdata[2]),
    .m_tvalid_o(m_tvalid[2]), .m_tready_i(m_tready[2]), .m_tlast_o(m_tlast[2]), .m_tdata_o(m_tdata[2]),
    .level_o(level2)
`ifdef AXIS_PFIFO_DROP_EN
    , .drop_o(drop2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    n_checks++;
    assert (cond) else begin
      n_err++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0: return sb0.size();
      1: return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic push(input int idx);
    beat_t b;
    b.d = s_tdata[idx];
    b.l = s_tlast[idx];
    b.e = cyc + 1;
    case (idx)
      0: sb0.push_back(b);
      1: sb1.push_back(b);
      default: sb2.push_back(b);
    endcase
  endtask

  task automatic pop_check(input int idx);
    beat_t exp;
    int sz;
    sz = qsize(idx);
    chk_true($sformatf("u%0d_unexpected_beat", idx), sz > 0);
    if (sz > 0) begin
      case (idx)
        0: exp = sb0.pop_front();
        1: exp = sb1.pop_front();
        default: exp = sb2.pop_front();
      endcase
      chk($sformatf("u%0d_data", idx), 32'(m_tdata[idx]), 32'(exp.d));
      chk($sformatf("u%0d_last", idx), 32'(m_tlast[idx]), 32'(exp.l));
      if (idx == 0 && lat_chk) chk("u0_latency", cyc + 1 - exp.e, 2);
    end
  endtask

  // Observe handshakes at the falling edge, then advance one rising edge.
  task automatic step();
    @(negedge aclk);
    acc_flag = '0;
    for (int i = 0; i < 3; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        acc_flag[i] = 1'b1;
        acc_cnt[i]++;
        if (!skip[i]) push(i);
      end
      if (m_tvalid[i] && m_tready[i]) begin
        out_cnt[i]++;
        pop_check(i);
      end
    end
`ifdef AXIS_PFIFO_DROP_EN
    if (drop2) drop_cnt++;
`endif
    @(posedge aclk);
    cyc++;
    #1;
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic l, input bit rnd);
    int n = 0;
    s_tvalid[idx] = 1'b1;
    s_tdata[idx]  = d;
    s_tlast[idx]  = l;
    do begin
      if (rnd) m_tready[idx] = 1'($urandom_range(0, 1));
      step();
      n++;
    end while (!acc_flag[idx] && n < 200);
    chk_true($sformatf("u%0d_accept_timeout", idx), acc_flag[idx] == 1'b1);
    s_tvalid[idx] = 1'b0;
    s_tlast[idx]  = 1'b0;
  endtask

  task automatic drain(input int idx);
    int n = 0;
    m_tready[idx] = 1'b1;
    while ((qsize(idx) != 0 || m_tvalid[idx]) && n < 200) begin
      step();
      n++;
    end
    chk($sformatf("u%0d_drain_left", idx), 32'(qsize(idx)), 32'd0);
    chk($sformatf("u%0d_drain_valid", idx), 32'(m_tvalid[idx]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int len;

    // Reset state of all instances
    repeat (3) @(posedge aclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_rst_tready", i), 32'(s_tready[i]), 32'd0);
      chk($sformatf("u%0d_rst_tvalid", i), 32'(m_tvalid[i]), 32'd0);
      chk($sformatf("u%0d_rst_tlast", i), 32'(m_tlast[i]), 32'd0);
      chk($sformatf("u%0d_rst_tdata", i), 32'(m_tdata[i]), 32'd0);
    end
    chk("u0_rst_level", 32'(level0), 32'd0);
    chk("u1_rst_level", 32'(level1), 32'd0);
    chk("u2_rst_level", 32'(level2), 32'd0);
`ifdef AXIS_PFIFO_DROP_EN
    chk("u2_rst_drop", 32'(drop2), 32'd0);
`endif
    aresetn = 1'b1;
    step();
    chk("u0_tready_after_rst", 32'(s_tready[0]), 32'd1);
    chk("u0_idle_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("u0_idle_level", 32'(level0), 32'd0);

    // Cut-through: 100 beats, sink always ready, fixed two-edge latency
    m_tready[0] = 1'b1;
    lat_chk = 1'b1;
    out_cnt[0] = 0;
    for (int i = 1; i <= 100; i++) send(0, 8'($urandom), i == 100, 1'b0);
    drain(0);
    lat_chk = 1'b0;
    chk("u0_ct_count", 32'(out_cnt[0]), 32'd100);

    // Full and backpressure: 9 beats fit (8 in RAM plus the output register)
    m_tready[0] = 1'b0;
    a0 = acc_cnt[0];
    out_cnt[0] = 0;
    s_tvalid[0] = 1'b1;
    s_tlast[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      s_tdata[0] = 8'(k * 37 + 11);
      step();
      if (!s_tready[0]) break;
    end
    chk("u0_full_accepted", 32'(acc_cnt[0] - a0), 32'd9);
    chk("u0_full_level", 32'(level0), 32'd8);
    chk("u0_full_tready", 32'(s_tready[0]), 32'd0);
    step();
    chk("u0_full_hold_tready", 32'(s_tready[0]), 32'd0);
    chk("u0_full_hold_tvalid", 32'(m_tvalid[0]), 32'd1);
    s_tvalid[0] = 1'b0;
    drain(0);
    chk("u0_full_out_count", 32'(out_cnt[0]), 32'd9);
    chk("u0_full_level_empty", 32'(level0), 32'd0);

    // Store-and-forward: nothing leaves until the tlast beat is stored
    m_tready[1] = 1'b1;
    out_cnt[1] = 0;
    for (int b = 0; b < 6; b++) begin
      send(1, 8'(8'hA0 + b), b == 5, 1'b0);
      chk($sformatf("u1_saf_hold_b%0d", b), 32'(m_tvalid[1]), 32'd0);
      if (b < 5) begin
        step();
        chk($sformatf("u1_saf_gap1_b%0d", b), 32'(m_tvalid[1]), 32'd0);
        step();
        chk($sformatf("u1_saf_gap2_b%0d", b), 32'(m_tvalid[1]), 32'd0);
      end
    end
    step();
    chk("u1_saf_release", 32'(m_tvalid[1]), 32'd1);
    drain(1);
    chk("u1_saf_count", 32'(out_cnt[1]), 32'd6);

    // Pointer wrap: 50 packets of 1..4 beats with a random sink
    out_cnt[2] = 0;
    a0 = 0;
    for (int p = 0; p < 50; p++) begin
      len = $urandom_range(1, 4);
      a0 += len;
      for (int b = 0; b < len; b++) send(2, 8'($urandom), b == len - 1, 1'b1);
    end
    drain(2);
    chk("u2_wrap_count", 32'(out_cnt[2]), 32'(a0));

`ifdef AXIS_PFIFO_DROP_EN
    // Oversize packet B is discarded; A and C survive
    drop_cnt = 0;
    out_cnt[2] = 0;
    m_tready[2] = 1'b1;
    for (int b = 0; b < 3; b++) send(2, 8'(8'h10 + b), b == 2, 1'b0);
    skip[2] = 1'b1;
    for (int b = 0; b < 7; b++) send(2, 8'(8'h20 + b), b == 6, 1'b0);
    chk("u2_drop_pulse", 32'(drop2), 32'd1);
    skip[2] = 1'b0;
    for (int b = 0; b < 2; b++) send(2, 8'(8'h30 + b), b == 1, 1'b0);
    drain(2);
    chk("u2_drop_out_count", 32'(out_cnt[2]), 32'd5);
    chk("u2_drop_pulses", 32'(drop_cnt), 32'd1);
`endif

    // Asynchronous reset with data held: outputs clear without a clock edge
    m_tready[0] = 1'b0;
    for (int b = 0; b < 3; b++) send(0, 8'(8'hC0 + b), b == 2, 1'b0);
    chk("u0_pre_rst_level", 32'(level0), 32'd2);
    aresetn = 1'b0;
    #1;
    chk("u0_async_rst_tready", 32'(s_tready[0]), 32'd0);
    chk("u0_async_rst_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("u0_async_rst_tdata", 32'(m_tdata[0]), 32'd0);
    chk("u0_async_rst_level", 32'(level0), 32'd0);
    sb0.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();
    chk("u0_rst2_tready", 32'(s_tready[0]), 32'd1);
    step();
    chk("u0_rst2_tvalid", 32'(m_tvalid[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
